muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RISC-V M-extension unit.
// A single shared hi/lo register pair serves as the shift-add product register
// for multiplies and as the remainder/quotient pair for restoring division.
// Each op takes one iteration per cycle over XLEN cycles, followed by a sign-fix cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [4:0]      LAST_CNT = 5'(XLEN - 1);
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]      state_reg;
  logic [4:0]      cnt_reg;
  logic [2:0]      f3_reg;
  logic            sign_a_reg;
  logic            sign_b_reg;
  // Multiplicand magnitude for MUL ops, divisor magnitude for DIV ops.
  logic [XLEN-1:0] opnd_reg;
  // MUL: {hi,lo} is the running product, with lo initially holding the multiplier.
  // DIV: hi is the partial remainder, and lo shifts the dividend out as the quotient shifts in.
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic [XLEN-1:0] result_reg;

  // Decode signedness and operand magnitudes at the start edge.
  logic            a_signed, b_signed;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_by_zero, div_overflow;
  logic [XLEN-1:0] fast_result;

  always_comb begin
    if (funct3[2]) begin
      a_signed = ~funct3[0];
      b_signed = ~funct3[0];
    end else begin
      a_signed = (funct3[1:0] != 2'b11);
      b_signed = ~funct3[1];
    end
    sign_a       = a_signed & op_a[XLEN-1];
    sign_b       = b_signed & op_b[XLEN-1];
    mag_a        = sign_a ? (~op_a + 1'b1) : op_a;
    mag_b        = sign_b ? (~op_b + 1'b1) : op_b;
    div_by_zero  = (op_b == '0);
    div_overflow = ~funct3[0] & (op_a == MIN_NEG) & (op_b == ALL_ONES);
    if (div_by_zero)
      fast_result = funct3[1] ? op_a : ALL_ONES;
    else
      fast_result = funct3[1] ? '0 : MIN_NEG;
  end

  // One shift-add or restoring-subtract step per cycle.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {hi_reg, lo_reg[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    div_diff  = div_shift - {1'b0, opnd_reg};
  end

  // Apply signs to the raw magnitudes and pick the half or the quotient/remainder to return.
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  always_comb begin
    prod_raw = {hi_reg, lo_reg};
    prod_fix = (sign_a_reg ^ sign_b_reg) ? (~prod_raw + 1'b1) : prod_raw;
    quo_fix  = (sign_a_reg ^ sign_b_reg) ? (~lo_reg + 1'b1) : lo_reg;
    rem_fix  = sign_a_reg ? (~hi_reg + 1'b1) : hi_reg;
    if (!f3_reg[2])
      fix_result = (f3_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else
      fix_result = f3_reg[1] ? rem_fix : quo_fix;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      f3_reg     <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      opnd_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      result_reg <= '0;
    end else if (flush) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          cnt_reg <= '0;
          if (start) begin
            f3_reg     <= funct3;
            sign_a_reg <= sign_a;
            sign_b_reg <= sign_b;
            hi_reg     <= '0;
            if (!funct3[2]) begin
              opnd_reg  <= mag_a;
              lo_reg    <= mag_b;
              state_reg <= S_MUL;
            end else if (!div_by_zero && !div_overflow) begin
              opnd_reg  <= mag_b;
              lo_reg    <= mag_a;
              state_reg <= S_DIV;
            end else begin
              opnd_reg   <= mag_b;
              lo_reg     <= mag_a;
              result_reg <= fast_result;
              state_reg  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          hi_reg  <= mul_sum[XLEN:1];
          lo_reg  <= {mul_sum[0], lo_reg[XLEN-1:1]};
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == LAST_CNT) state_reg <= S_FIX;
        end
        S_DIV: begin
          hi_reg  <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
          lo_reg  <= {lo_reg[XLEN-2:0], div_ge};
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == LAST_CNT) state_reg <= S_FIX;
        end
        S_FIX: begin
          result_reg <= fix_result;
          state_reg  <= S_DONE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_reg == S_MUL) || (state_reg == S_DIV) || (state_reg == S_FIX);
  assign valid  = (state_reg == S_DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: a table of directed ops with hand-computed results,
// plus hand-written flush, reset and priority sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  logic [31:0] prev_result;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op at edge E0. Then observe it for 37 cycles. After that, compare the
  // first valid edge, the pulse count, the busy span, the busy/valid overlap and the result.
  // If restart_at is 0 or more, a second start is pulsed at that cycle.
  // That second start is a fast-path DIVU by zero, and it must be ignored.
  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit fast,
                       input int restart_at);
    int first_valid, n_valid, n_busy, last_busy, overlap;
    logic [31:0] res_at_valid;
    first_valid = -1; n_valid = 0; n_busy = 0; last_busy = -1; overlap = 0;
    res_at_valid = 32'hDEADBEEF;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = ~f; op_a = ~a; op_b = ~b;
    if (!fast) chk({name, " hold"}, result, prev_result);
    for (int k = 0; k <= 36; k++) begin
      if (k == restart_at) begin
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1; op_b = 32'd0;
      end
      if (restart_at >= 0 && k == restart_at + 1) start = 1'b0;
      if (valid) begin
        n_valid++;
        if (first_valid < 0) begin
          first_valid  = k;
          res_at_valid = result;
        end
      end
      if (busy) begin
        n_busy++;
        last_busy = k;
      end
      if (busy && valid) overlap++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({name, " valid_edge"}, 32'(first_valid), fast ? 32'd0 : 32'd33);
    chk({name, " valid_count"}, 32'(n_valid), 32'd1);
    chk({name, " busy_count"}, 32'(n_busy), fast ? 32'd0 : 32'd33);
    if (!fast) chk({name, " busy_last"}, 32'(last_busy), 32'd32);
    chk({name, " overlap"}, 32'(overlap), 32'd0);
    chk({name, " result"}, res_at_valid, exp);
    chk({name, " result_held"}, result, exp);
    $display("op %-14s f=%b a=0x%08h b=0x%08h -> 0x%08h (want 0x%08h) valid@E%0d",
             name, f, a, b, res_at_valid, exp, first_valid);
    prev_result = exp;
  endtask

  initial begin
    int n_valid;
    vecs[0]  = '{"MUL_7x-3",      3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{"MULHU_ff",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{"MULH_ff",       3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[3]  = '{"MULHSU_ff",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{"DIV_-7/2",      3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{"REM_-7/2",      3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{"DIVU_100/7",    3'b101, 32'd100,      32'd7,        32'd14,       1'b0};
    vecs[7]  = '{"REMU_100/7",    3'b111, 32'd100,      32'd7,        32'd2,        1'b0};
    vecs[8]  = '{"DIVU_5/0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{"REM_5/0",       3'b110, 32'd5,        32'd0,        32'd5,        1'b1};
    vecs[10] = '{"DIV_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{"REM_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[12] = '{"DIV_7/-2",      3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[13] = '{"REM_7/-2",      3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[14] = '{"DIVU_max/16",   3'b101, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 1'b0};
    vecs[15] = '{"REMU_max/16",   3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1'b0};
    vecs[16] = '{"MUL_2^16sq",    3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0};
    vecs[17] = '{"MULHU_2^16sq",  3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0};
    vecs[18] = '{"DIVU_ovfpat",   3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[19] = '{"REMU_0/0",      3'b111, 32'd0,        32'd0,        32'd0,        1'b1};

    // Reset with start and flush also high: reset must win.
    rst = 1'b1; start = 1'b1; flush = 1'b1; funct3 = 3'b101; op_a = 32'd5; op_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle valid", {31'd0, valid}, 32'd0);
    prev_result = 32'd0;

    // Main vector table.
    for (int i = 0; i < 20; i++)
      do_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].fast, -1);

    // Flush beats start in IDLE. Without flush, a fast-path op would give valid on the next cycle.
    funct3 = 3'b101; op_a = 32'd5; op_b = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_prio valid", {31'd0, valid}, 32'd0);
    chk("flush_prio busy", {31'd0, busy}, 32'd0);
    chk("flush_prio result", result, prev_result);
    $display("seq flush_prio: valid=%b busy=%b result=0x%08h", valid, busy, result);

    // Flush at edge E10 of a DIVU.
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("flush pre busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush valid", {31'd0, valid}, 32'd0);
    chk("flush result", result, prev_result);
    n_valid = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid || busy) n_valid++;
      @(posedge clk); #1;
    end
    chk("flush quiet", 32'(n_valid), 32'd0);
    $display("seq flush@E10: busy=%b valid=%b result=0x%08h activity=%0d", busy, valid, result, n_valid);

    // MUL 3x4, with a second start pulsed while the unit is busy.
    do_op("MUL_3x4_restart", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, 5);

    // Reset at edge E5 of a MUL.
    funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst valid", {31'd0, valid}, 32'd0);
    chk("midrst result", result, 32'd0);
    n_valid = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid || busy) n_valid++;
      @(posedge clk); #1;
    end
    chk("midrst quiet", 32'(n_valid), 32'd0);
    $display("seq rst@E5: busy=%b valid=%b result=0x%08h activity=%0d", busy, valid, result, n_valid);
    prev_result = 32'd0;

    do_op("DIVU_9/3", 3'b101, 32'd9, 32'd3, 32'd3, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
